branch_ctrl: RTL and testbench

Next-PC control stage that sits directly upstream of the program counter and drives its `absjump_en`/`target` inputs every cycle. It resolves conditional branches, unconditional jumps, calls and returns from decoder strobes and the ALU condition flag. Branch/jump/call destinations come from a target lookup table indexed by a short instruction field. Return addresses are held in a small hardware return stack, with sticky overflow/underflow flags for debug.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_ctrl_jump_lut.sv | 11 +
 rtl/branch_ctrl.sv | 101 ++++++++++
 tb/tb_branch_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the next-PC control stage.
// JUMP_TARGETS is regenerated by the assembler flow; keep its size at 2**LUT_W.
package branch_pkg;

  localparam int D     = 10;
  localparam int DEPTH = 4;
  localparam int LUT_W = 5;

  typedef logic [D-1:0] pc_t;

  localparam pc_t JUMP_TARGETS [2**LUT_W] = '{
    10'd7,   10'd27,  10'd47,  10'd67,  10'd87,  10'd107, 10'd127, 10'd147,
    10'd167, 10'd187, 10'd207, 10'd227, 10'd247, 10'd267, 10'd287, 10'd307,
    10'd327, 10'd347, 10'd367, 10'd387, 10'd407, 10'd427, 10'd447, 10'd467,
    10'd487, 10'd507, 10'd527, 10'd547, 10'd567, 10'd587, 10'd607, 10'd627
  };

endpackage

// File: rtl/branch_ctrl_jump_lut.sv
// Combinational branch/jump/call destination lookup from the assembler-owned table.
module jump_lut
  import branch_pkg::*;
(
  input  logic [LUT_W-1:0] lut_idx,
  output pc_t              target
);

  assign target = JUMP_TARGETS[lut_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Next-PC control: resolves branch/jump/call/return and owns the return stack.
// Optional RAS_WRAP_EN makes the return stack circular (overwrite oldest when full).
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [D-1:0]     prog_ctr,
  input  logic             br_en,
  input  logic             cond,
  input  logic             jmp_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [LUT_W-1:0] lut_idx,
  output logic             absjump_en,
  output logic [D-1:0]     target,
  output logic [CW-1:0]    depth,
  output logic             stk_ovf,
  output logic             stk_unf
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  pc_t           lut_target;
  logic [D-1:0]  stack [DEPTH];
  logic [PW-1:0] ptr;      // next free slot; top of stack is ptr-1
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic          do_ret;
  logic          do_call;
  logic          do_jmp;
  logic          do_br;
  logic          empty;
  logic          full;

  jump_lut u_jump_lut (
    .lut_idx (lut_idx),
    .target  (lut_target)
  );

  assign ptr_inc = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign ptr_dec = (ptr == '0) ? LAST : ptr - 1'b1;
  assign empty   = (depth == '0);
  assign full    = (depth == FULL);

  assign do_ret  = ret_en;
  assign do_call = !ret_en && call_en;
  assign do_jmp  = !ret_en && !call_en && jmp_en;
  assign do_br   = !ret_en && !call_en && !jmp_en && br_en;

  always_comb begin
    absjump_en = 1'b0;
    target     = lut_target;
    if (!reset) begin
      absjump_en = 1'b0;
    end else if (do_ret) begin
      if (!empty) begin
        absjump_en = 1'b1;
        target     = stack[ptr_dec];
      end
    end else if (do_call || do_jmp) begin
      absjump_en = 1'b1;
    end else if (do_br) begin
      absjump_en = cond;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
      ptr     <= '0;
      depth   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else if (do_ret) begin
      if (empty) begin
        stk_unf <= 1'b1;
      end else begin
        ptr   <= ptr_dec;
        depth <= depth - 1'b1;
      end
    end else if (do_call) begin
      if (full) begin
        stk_ovf <= 1'b1;
`ifdef RAS_WRAP_EN
        stack[ptr] <= prog_ctr + 1'b1;
        ptr        <= ptr_inc;
`endif
      end else begin
        stack[ptr] <= prog_ctr + 1'b1;
        ptr        <= ptr_inc;
        depth      <= depth + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] prog_ctr;
  logic       br_en, cond, jmp_en, call_en, ret_en;
  logic [4:0] lut_idx;
  logic       absjump_en;
  logic [9:0] target;
  logic [2:0] depth;
  logic       stk_ovf, stk_unf;

  int n_chk  = 0;
  int n_fail = 0;

  branch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .prog_ctr   (prog_ctr),
    .br_en      (br_en),
    .cond       (cond),
    .jmp_en     (jmp_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .lut_idx    (lut_idx),
    .absjump_en (absjump_en),
    .target     (target),
    .depth      (depth),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic b, input logic c, input logic j, input logic cl,
                     input logic r, input logic [4:0] idx, input logic [9:0] pc);
    br_en = b; cond = c; jmp_en = j; call_en = cl; ret_en = r;
    lut_idx = idx; prog_ctr = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drv(0, 0, 0, 0, 0, 5'd0, 10'd0);
  endtask

  int call_pc [3] = '{10, 50, 90};
  int ret_tgt [3] = '{91, 51, 11};
  int ovf_ret [4];

  initial begin
`ifdef RAS_WRAP_EN
    ovf_ret = '{6, 5, 4, 3};
`else
    ovf_ret = '{5, 4, 3, 2};
`endif
    reset = 1'b0;
    drv(0, 0, 1, 0, 0, 5'd0, 10'd0);
    #11;
    chk("rst_abs", absjump_en, 0);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", stk_ovf, 0);
    chk("rst_unf", stk_unf, 0);
    @(negedge clk) reset = 1'b1;
    tick();

    // branch / jump / idle
    drv(1, 0, 0, 0, 0, 5'd3, 10'd0);  chk("br_nt_abs", absjump_en, 0);
    drv(1, 1, 0, 0, 0, 5'd3, 10'd0);  chk("br_t_abs", absjump_en, 1);
    chk("br_t_tgt", target, 67);
    drv(0, 0, 1, 0, 0, 5'd5, 10'd0);  chk("jmp_abs", absjump_en, 1);
    chk("jmp_tgt", target, 107);
    drv(1, 0, 1, 0, 0, 5'd31, 10'd0); chk("jmp_over_br", absjump_en, 1);
    chk("jmp_tgt31", target, 627);
    drv(0, 1, 0, 0, 0, 5'd0, 10'd0);  chk("idle_abs", absjump_en, 0);
    chk("idle_tgt", target, 7);

    // nested calls then returns
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 1, 0, 5'd2, 10'(call_pc[i]));
      chk("call_abs", absjump_en, 1);
      chk("call_tgt", target, 47);
      tick();
      chk("call_depth", depth, i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 1, 5'd0, 10'd0);
      chk("ret_abs", absjump_en, 1);
      chk("ret_tgt", target, ret_tgt[i]);
      tick();
      chk("ret_depth", depth, 2 - i);
    end

    // PC wraps on push; return on the very next cycle
    drv(0, 0, 0, 1, 0, 5'd1, 10'd1023);
    @(posedge clk); #1;
    drv(0, 0, 0, 0, 1, 5'd0, 10'd0);
    chk("wrap_ret_abs", absjump_en, 1);
    chk("wrap_ret_tgt", target, 0);
    tick();
    chk("wrap_depth", depth, 0);

    // underflow
    drv(0, 0, 0, 0, 1, 5'd4, 10'd0);
    chk("unf_abs", absjump_en, 0);
    tick();
    chk("unf_flag", stk_unf, 1);
    chk("unf_depth", depth, 0);
    tick(); tick();
    chk("unf_sticky", stk_unf, 1);

    // overflow
    for (int i = 1; i <= 5; i++) begin
      drv(0, 0, 0, 1, 0, 5'd6, 10'(i));
      chk("ovf_call_abs", absjump_en, 1);
      tick();
    end
    chk("ovf_flag", stk_ovf, 1);
    chk("ovf_depth", depth, 4);
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 1, 5'd0, 10'd0);
      chk("ovf_ret_tgt", target, ovf_ret[i]);
      tick();
    end
    chk("ovf_drained", depth, 0);
    chk("ovf_sticky", stk_ovf, 1);

    // priority: ret over call
    drv(0, 0, 0, 1, 0, 5'd0, 10'd100); tick();
    drv(0, 0, 0, 1, 0, 5'd0, 10'd200); tick();
    drv(0, 0, 1, 1, 1, 5'd9, 10'd300);
    chk("prio_abs", absjump_en, 1);
    chk("prio_tgt", target, 201);
    tick();
    chk("prio_depth", depth, 1);
    drv(0, 0, 0, 0, 1, 5'd0, 10'd0);
    chk("prio_nopush", target, 101);
    tick();

    // asynchronous reset mid-operation
    drv(0, 0, 0, 1, 0, 5'd0, 10'd400); tick();
    chk("pre_rst_depth", depth, 1);
    #3;
    drv(0, 0, 1, 0, 0, 5'd3, 10'd0);
    reset = 1'b0;
    #1;
    chk("arst_abs", absjump_en, 0);
    chk("arst_depth", depth, 0);
    chk("arst_ovf", stk_ovf, 0);
    chk("arst_unf", stk_unf, 0);
    @(negedge clk) reset = 1'b1;
    drv(0, 0, 0, 0, 1, 5'd0, 10'd0);
    chk("post_rst_ret_abs", absjump_en, 0);
    tick();
    chk("post_rst_unf", stk_unf, 1);
    chk("post_rst_depth", depth, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
